// File: rtl/camac_pkg.sv
// Shared types and defaults for the CAMAC dataway cycle controller.
// CAMAC_Z_CYCLE_EN adds the dataway-initialise (Z) states to the state enum.
package camac_pkg;

    localparam int T_SETUP_DEF = 4;
    localparam int T_S1_DEF    = 4;
    localparam int T_GAP_DEF   = 4;
    localparam int T_S2_DEF    = 4;
    localparam int T_HOLD_DEF  = 4;

    typedef enum logic [2:0] {
        ST_IDLE, ST_SETUP, ST_S1, ST_GAP, ST_S2, ST_HOLD
`ifdef CAMAC_Z_CYCLE_EN
        , ST_ZSETUP, ST_ZS2, ST_ZHOLD
`endif
    } state_e;

    typedef enum logic [1:0] {FC_READ, FC_WRITE, FC_CTRL} fclass_e;

    // F0..F7 read, F16..F23 write, everything else is a control function
    function automatic fclass_e f_class(input logic [4:0] f);
        case (f[4:3])
            2'b00:   return FC_READ;
            2'b10:   return FC_WRITE;
            default: return FC_CTRL;
        endcase
    endfunction

    function automatic int max5(input int a, input int b, input int c, input int d, input int e);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        if (e > m) m = e;
        return m;
    endfunction

endpackage

// File: rtl/camac_cycle_ctrl_if.sv
// ISA-side request / dataway-side bus bundle for camac_cycle_ctrl.
interface camac_cycle_ctrl_if;
    logic        start;
    logic [4:0]  n_in;
    logic [3:0]  a_in;
    logic [4:0]  f_in;
    logic [23:0] wdata_in;
    logic [23:0] r_in;
    logic        q_in;
    logic        x_in;
    logic        z_req;
    logic [4:0]  n_out;
    logic [3:0]  a_out;
    logic [4:0]  f_out;
    logic [23:0] w_out;
    logic        naf_e1_n;
    logic        naf_e2_n;
    logic        w_e1_n;
    logic        w_e2_n;
    logic        busy;
    logic        s1;
    logic        s2;
    logic        z;
    logic [23:0] rdata;
    logic        q_out;
    logic        x_out;
    logic        done;
    logic        ready;

    modport master (
        output start, n_in, a_in, f_in, wdata_in, r_in, q_in, x_in, z_req,
        input  n_out, a_out, f_out, w_out, naf_e1_n, naf_e2_n, w_e1_n, w_e2_n,
               busy, s1, s2, z, rdata, q_out, x_out, done, ready
    );

    modport slave (
        input  start, n_in, a_in, f_in, wdata_in, r_in, q_in, x_in, z_req,
        output n_out, a_out, f_out, w_out, naf_e1_n, naf_e2_n, w_e1_n, w_e2_n,
               busy, s1, s2, z, rdata, q_out, x_out, done, ready
    );
endinterface

// File: rtl/camac_strobe_timer.sv
// Loadable down-counter timing each dataway phase; zero_o flags the last cycle of a phase.
module camac_strobe_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] val_i,
    output logic         zero_o
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)            cnt_d = val_i;
        else if (cnt_q != '0)  cnt_d = cnt_q - W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/camac_cycle_ctrl.sv
// One CAMAC dataway cycle (BUSY/S1/S2) per ISA request, driving the LS365/366 line drivers.
// Define CAMAC_Z_CYCLE_EN to enable the Z (initialise) cycle on z_req.
module camac_cycle_ctrl
    import camac_pkg::*;
#(
    parameter int T_SETUP = T_SETUP_DEF,
    parameter int T_S1    = T_S1_DEF,
    parameter int T_GAP   = T_GAP_DEF,
    parameter int T_S2    = T_S2_DEF,
    parameter int T_HOLD  = T_HOLD_DEF
) (
    input logic               clk,
    input logic               rst,
    camac_cycle_ctrl_if.slave bus
);
    localparam int T_MAX = max5(T_SETUP, T_S1, T_GAP, T_S2, T_HOLD);
    localparam int TW    = $clog2(T_MAX + 1);

    state_e          state_q, state_d;
    logic            tmr_load, tmr_zero, accept;
    logic [TW-1:0]   tmr_val;
    logic [4:0]      n_q, f_q, f_d;
    logic [3:0]      a_q;
    logic [23:0]     w_q, rdata_q;
    logic            q_out_q, x_out_q;
    logic            busy_q, s1_q, s2_q, z_q, done_q, ready_q, naf_en_n_q, w_en_n_q;
    logic            drive_d, zcyc_d, s2_d;

    camac_strobe_timer #(.W(TW)) u_tmr (
        .clk    (clk),
        .rst    (rst),
        .load_i (tmr_load),
        .val_i  (tmr_val),
        .zero_o (tmr_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Each phase reloads the timer with its width minus one on entry
    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        accept   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
`ifdef CAMAC_Z_CYCLE_EN
                if (bus.z_req) begin
                    state_d = ST_ZSETUP; tmr_load = 1'b1; tmr_val = TW'(T_SETUP - 1);
                end else if (bus.start) begin
                    state_d = ST_SETUP; tmr_load = 1'b1; tmr_val = TW'(T_SETUP - 1); accept = 1'b1;
                end
`else
                if (bus.start) begin
                    state_d = ST_SETUP; tmr_load = 1'b1; tmr_val = TW'(T_SETUP - 1); accept = 1'b1;
                end
`endif
            end
            ST_SETUP: if (tmr_zero) begin state_d = ST_S1;  tmr_load = 1'b1; tmr_val = TW'(T_S1 - 1);   end
            ST_S1:    if (tmr_zero) begin state_d = ST_GAP; tmr_load = 1'b1; tmr_val = TW'(T_GAP - 1);  end
            ST_GAP:   if (tmr_zero) begin state_d = ST_S2;  tmr_load = 1'b1; tmr_val = TW'(T_S2 - 1);   end
            ST_S2:    if (tmr_zero) begin state_d = ST_HOLD; tmr_load = 1'b1; tmr_val = TW'(T_HOLD - 1); end
            ST_HOLD:  if (tmr_zero) state_d = ST_IDLE;
`ifdef CAMAC_Z_CYCLE_EN
            ST_ZSETUP: if (tmr_zero) begin state_d = ST_ZS2;   tmr_load = 1'b1; tmr_val = TW'(T_S2 - 1);   end
            ST_ZS2:    if (tmr_zero) begin state_d = ST_ZHOLD; tmr_load = 1'b1; tmr_val = TW'(T_HOLD - 1); end
            ST_ZHOLD:  if (tmr_zero) state_d = ST_IDLE;
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        drive_d = 1'b0;
        zcyc_d  = 1'b0;
        s2_d    = 1'b0;
        case (state_d)
            ST_SETUP, ST_S1, ST_GAP, ST_HOLD: drive_d = 1'b1;
            ST_S2: begin drive_d = 1'b1; s2_d = 1'b1; end
`ifdef CAMAC_Z_CYCLE_EN
            ST_ZSETUP, ST_ZHOLD: zcyc_d = 1'b1;
            ST_ZS2: begin zcyc_d = 1'b1; s2_d = 1'b1; end
`endif
            default: ;
        endcase
    end

    assign f_d = accept ? bus.f_in : f_q;

    // Strobes and enables are registered from next state so the dataway sees clean edges
    always_ff @(posedge clk) begin
        if (rst) begin
            n_q <= '0; a_q <= '0; f_q <= '0; w_q <= '0;
            rdata_q <= '0; q_out_q <= 1'b0; x_out_q <= 1'b0;
            busy_q <= 1'b0; s1_q <= 1'b0; s2_q <= 1'b0; z_q <= 1'b0; done_q <= 1'b0;
            ready_q <= 1'b1; naf_en_n_q <= 1'b1; w_en_n_q <= 1'b1;
        end else begin
            if (accept) begin
                n_q <= bus.n_in; a_q <= bus.a_in; f_q <= bus.f_in; w_q <= bus.wdata_in;
            end
            if (state_q == ST_S1 && tmr_zero) begin
                if (f_class(f_q) == FC_READ) rdata_q <= bus.r_in;
                q_out_q <= bus.q_in;
                x_out_q <= bus.x_in;
            end
            busy_q     <= (state_d != ST_IDLE);
            s1_q       <= (state_d == ST_S1);
            s2_q       <= s2_d;
            z_q        <= zcyc_d;
            naf_en_n_q <= ~drive_d;
            w_en_n_q   <= ~(drive_d && f_class(f_d) == FC_WRITE);
            done_q     <= (state_q != ST_IDLE) && (state_d == ST_IDLE);
            ready_q    <= (state_d == ST_IDLE);
        end
    end

`ifndef CAMAC_Z_CYCLE_EN
    logic unused_z;
    assign unused_z = bus.z_req;
`endif

    assign bus.n_out    = n_q;
    assign bus.a_out    = a_q;
    assign bus.f_out    = f_q;
    assign bus.w_out    = w_q;
    assign bus.naf_e1_n = naf_en_n_q;
    assign bus.naf_e2_n = naf_en_n_q;
    assign bus.w_e1_n   = w_en_n_q;
    assign bus.w_e2_n   = w_en_n_q;
    assign bus.busy     = busy_q;
    assign bus.s1       = s1_q;
    assign bus.s2       = s2_q;
    assign bus.z        = z_q;
    assign bus.rdata    = rdata_q;
    assign bus.q_out    = q_out_q;
    assign bus.x_out    = x_out_q;
    assign bus.done     = done_q;
    assign bus.ready    = ready_q;
endmodule
